exe_muldiv: RTL and testbench
=============================

Name: exe_muldiv

Overview:
Iterative RV32M execute unit, parametrised in operand width. It handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits in the execute stage beside the single-cycle R-type ALU and claims R-type instructions with funct7 = 0000001. It uses a valid/ready handshake on both sides so the pipeline can stall on it.

Parameters:
XLEN, 32, operand and result width (power of two, >= 8)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override)

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
flush_i  input  1  synchronous kill of any in-flight op
valid_i  input  1  issue request
ready_o  output  1  unit can accept (state IDLE)
inst_i  input  32  instruction word
op1_i  input  XLEN  rs1 value
op2_i  input  XLEN  rs2 value
rd_i  input  5  destination register
valid_o  output  1  result available
ready_i  input  1  writeback accepts result
rd_o  output  5  destination of result
reg_wdata_o  output  XLEN  result
reg_we_o  output  1  write enable, equals valid_o

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - state IDLE; counter, operand, accumulator and rd registers cleared.
  - valid_o=0, reg_we_o=0, reg_wdata_o=0, rd_o=0; ready_o=1 once in IDLE.
- Decode: isTypeM = (inst[6:0]==0110011) and (inst[31:25]==0000001). funct3 selects:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Accept: valid_i & ready_o & isTypeM & !flush_i at a rising edge.
  - Latches op, rd_i and operand magnitudes plus sign flags.
  - valid_i with !isTypeM is dropped silently; state stays IDLE.
- States: IDLE -> MUL | DIV | DONE; MUL/DIV -> DONE; DONE -> IDLE.
- MUL path:
  - Signed operands (MULH: both; MULHSU: op1 only) are converted to magnitude.
  - Unsigned shift-add, one bit per cycle, into a 2*XLEN accumulator.
  - Product is negated at the end if the result sign is set.
  - MUL returns the low XLEN bits; the other three return the high XLEN bits.
- DIV path:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient is negated if operand signs differ (DIV only).
  - Remainder takes the dividend sign (REM only).
- Normal latency: counter loads XLEN at accept and performs one iteration per edge. DONE is entered on the XLEN-th edge after the accepting edge, so valid_o is high in that cycle (32 for XLEN=32).
- Fast cases (accept edge goes directly to DONE; valid_o in the next cycle):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - Signed overflow (DIV/REM of MIN by -1): DIV -> MIN; REM -> 0.
- DONE:
  - valid_o=reg_we_o=1; reg_wdata_o and rd_o are held stable while ready_i=0.
  - valid_o & ready_i -> IDLE at that edge.
  - ready_o=0 in DONE; no same-cycle re-accept.
- Outputs outside DONE: reg_wdata_o=0, rd_o=0, valid_o=0.
- flush_i:
  - From any state, forces IDLE at the next edge; in-flight result is discarded with no valid_o.
  - Has priority over accept and over a DONE handshake in the same cycle.
- Reset mid-operation: immediate return to IDLE with all outputs cleared; no residual result after release.

Decomposition:
- Add to defines.v:
  - INST_TYPE_R_M opcode, FUN7_M
  - FUN3_MUL … FUN3_REMU codes
  - state encodings: IDLE, MUL, DIV, DONE
- One natural sub-module: exe_div_restoring. It holds the per-cycle quotient/remainder step and its registers, with start/busy/done, so the divider can be reused and tested standalone. Sign handling and the multiplier stay in exe_muldiv.

Test Plan:
- MUL 7 × 0xFFFFFFFD: reg_wdata_o=0xFFFFFFEB, rd_o=rd_i. valid_o rises exactly 32 edges after accept, one cycle long with ready_i=1.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF
- Divide and remainder:
  - DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF
  - DIVU 100/7 -> 14; REMU 100/7 -> 2
- Fast cases, each with valid_o one edge after accept:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0
- Backpressure and non-M drop:
  - Hold ready_i=0 for 5 cycles in DONE: valid_o, reg_wdata_o and rd_o stay stable and ready_o=0. Raise ready_i: IDLE next edge, ready_o=1.
  - Issue ADD (funct7 0000000): dropped, with no valid_o.
- Flush and reset mid-operation:
  - flush_i on iteration 10 of a DIVU: IDLE next edge, no valid_o. A new MUL is then accepted and completes correctly.
  - rst_n_i low mid-MUL: all outputs 0 immediately.

Source files
------------

// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide execute unit.
// Holds the R-type M-extension opcode/funct codes, the FSM state encoding
// and the decode helper that recognises an M-extension instruction.
package exe_muldiv_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUN7_M        = 7'b0000001;

  localparam logic [2:0] FUN3_MUL    = 3'b000;
  localparam logic [2:0] FUN3_MULH   = 3'b001;
  localparam logic [2:0] FUN3_MULHSU = 3'b010;
  localparam logic [2:0] FUN3_MULHU  = 3'b011;
  localparam logic [2:0] FUN3_DIV    = 3'b100;
  localparam logic [2:0] FUN3_DIVU   = 3'b101;
  localparam logic [2:0] FUN3_REM    = 3'b110;
  localparam logic [2:0] FUN3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_type_m(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == INST_TYPE_R_M) && (funct7 == FUN7_M);
  endfunction

endpackage

// File: rtl/exe_muldiv_if.sv
// Issue/writeback bundle of the multiply/divide unit.
// Issue side : valid_i, ready_o, inst_i, op1_i, op2_i, rd_i
// Result side: valid_o, ready_i, rd_o, reg_wdata_o, reg_we_o
// Signal suffixes are from the unit's point of view; the slave modport is
// the unit itself, the master modport is the pipeline driving it.
interface exe_muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_i;
  logic            valid_o;
  logic            ready_i;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] reg_wdata_o;
  logic            reg_we_o;

  modport master (
    output valid_i, inst_i, op1_i, op2_i, rd_i, ready_i,
    input  ready_o, valid_o, rd_o, reg_wdata_o, reg_we_o
  );

  modport slave (
    input  valid_i, inst_i, op1_i, op2_i, rd_i, ready_i,
    output ready_o, valid_o, rd_o, reg_wdata_o, reg_we_o
  );
endinterface

// File: rtl/exe_muldiv_div_restoring.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports: clk_i/rst_n_i clock and async active-low reset; clear_i aborts a
// division; start_i loads dividend_i/divisor_i; busy_o while iterating;
// done_o marks the cycle whose step is the last one, and in that cycle
// quotient_o/remainder_o already carry the final values (they present the
// result of the step about to be taken), so a consumer can register the
// answer on the same edge that completes the division.
module exe_div_restoring #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
  logic [XLEN-1:0]  quo_d, rem_d;
  logic [XLEN:0]    shifted, diff;

  // Partial remainder never exceeds the divisor, so one extra bit is enough
  // for the trial subtraction; its MSB is the borrow.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_d = diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d = shifted[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (clear_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_INIT;
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == CNT_W'(1));
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;
endmodule

// File: rtl/exe_muldiv.sv
// Iterative RV32M execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Ports: clk_i clock; rst_n_i async active-low reset; flush_i synchronous
// kill of any in-flight op; bus (slave) carries the issue handshake
// (valid_i/ready_o, inst_i, op1_i, op2_i, rd_i) and the result handshake
// (valid_o/ready_i, rd_o, reg_wdata_o, reg_we_o).
// Operands are converted to magnitudes at accept; the multiplier is a
// shift-add loop here, the divider is exe_div_restoring; the result sign is
// applied on the edge that enters DONE. Divide-by-zero and signed overflow
// skip the loop and go straight to DONE.
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input logic         clk_i,
  input logic         rst_n_i,
  input logic         flush_i,
  exe_muldiv_if.slave bus
);
  localparam logic [CNT_W-1:0]       CNT_INIT = CNT_W'(XLEN);
  localparam logic signed [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic signed [XLEN-1:0] SNEG1    = '1;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q, rd_out_q;
  logic              neg_q, valid_q;
  logic [XLEN-1:0]   mcand_q, wdata_q;
  logic [2*XLEN-1:0] acc_q;

  logic                   idle, is_m, accept, is_div, s1, s2, neg_d, dz, ov, fast;
  logic [2:0]             f3;
  logic signed [XLEN-1:0] op1_s, op2_s;
  logic [XLEN-1:0]        mag1, mag2, fast_res, mul_res, div_res;
  logic [XLEN:0]          sum;
  logic [2*XLEN-1:0]      acc_step, prod;
  logic                   div_done, unused_div_busy, unused_inst;
  logic [XLEN-1:0]        div_quo, div_rem;

  assign idle        = (state_q == ST_IDLE);
  assign f3          = bus.inst_i[14:12];
  assign is_m        = is_type_m(bus.inst_i[6:0], bus.inst_i[31:25]);
  assign accept      = bus.valid_i && idle && is_m && !flush_i;
  assign is_div      = f3[2];
  assign op1_s       = bus.op1_i;
  assign op2_s       = bus.op2_i;
  assign unused_inst = ^{bus.inst_i[24:15], bus.inst_i[11:7]};

  // Issue decode: sign flags, magnitudes and the two short-circuit cases.
  always_comb begin
    s1 = 1'b0;
    s2 = 1'b0;
    case (f3)
      FUN3_MULH, FUN3_DIV, FUN3_REM: begin
        s1 = op1_s[XLEN-1];
        s2 = op2_s[XLEN-1];
      end
      FUN3_MULHSU: s1 = op1_s[XLEN-1];
      default: ;
    endcase
    // A remainder follows the dividend; everything else follows the product/quotient sign.
    neg_d = (f3 == FUN3_REM) ? s1 : (s1 ^ s2);
    mag1  = cond_neg(bus.op1_i, s1);
    mag2  = cond_neg(bus.op2_i, s2);
    dz    = is_div && (bus.op2_i == '0);
    ov    = ((f3 == FUN3_DIV) || (f3 == FUN3_REM)) && (op1_s == SMIN) && (op2_s == SNEG1);
    fast  = dz || ov;
    if (dz) fast_res = f3[1] ? bus.op1_i : '1;
    else    fast_res = f3[1] ? '0 : SMIN;
  end

  // Shift-add step: low half starts as the multiplier and is shifted out as
  // the product grows in from the top.
  always_comb begin
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {sum, acc_q[XLEN-1:1]};
    prod     = neg_q ? -acc_step : acc_step;
    mul_res  = (op_q == FUN3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_res  = op_q[1] ? cond_neg(div_rem, neg_q) : cond_neg(div_quo, neg_q);
  end

  exe_div_restoring #(.XLEN(XLEN)) u_div (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (flush_i),
    .start_i    (accept && is_div && !fast),
    .dividend_i (mag1),
    .divisor_i  (mag2),
    .busy_o     (unused_div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      wdata_q  <= '0;
      rd_out_q <= '0;
    end else if (flush_i) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      wdata_q  <= '0;
      rd_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          op_q    <= f3;
          rd_q    <= bus.rd_i;
          neg_q   <= neg_d;
          cnt_q   <= CNT_INIT;
          mcand_q <= mag1;
          acc_q   <= {{XLEN{1'b0}}, mag2};
          if (fast) begin
            state_q  <= ST_DONE;
            valid_q  <= 1'b1;
            wdata_q  <= fast_res;
            rd_out_q <= bus.rd_i;
          end else if (is_div) begin
            state_q <= ST_DIV;
          end else begin
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q  <= ST_DONE;
            valid_q  <= 1'b1;
            wdata_q  <= mul_res;
            rd_out_q <= rd_q;
          end
        end
        ST_DIV: if (div_done) begin
          state_q  <= ST_DONE;
          valid_q  <= 1'b1;
          wdata_q  <= div_res;
          rd_out_q <= rd_q;
        end
        ST_DONE: if (bus.ready_i) begin
          state_q  <= ST_IDLE;
          valid_q  <= 1'b0;
          wdata_q  <= '0;
          rd_out_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_o     = idle;
  assign bus.valid_o     = valid_q;
  assign bus.reg_we_o    = valid_q;
  assign bus.reg_wdata_o = wdata_q;
  assign bus.rd_o        = rd_out_q;
endmodule

// File: tb/tb_exe_muldiv.sv
module tb_exe_muldiv;
  import exe_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  exe_muldiv_if #(.XLEN(32)) bus();

  exe_muldiv #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, INST_TYPE_R_M};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    int w;
    w = 0;
    while (bus.ready_o !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) check1("ready_wait", bus.ready_o, 1'b1);
    bus.valid_i = 1'b1;
    bus.inst_i  = inst;
    bus.op1_i   = a;
    bus.op2_i   = b;
    bus.rd_i    = rd;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.inst_i  = 32'd0;
    bus.op1_i   = 32'd0;
    bus.op2_i   = 32'd0;
    bus.rd_i    = 5'd0;
  endtask

  // Queue the expected result, issue, and measure edges from accept to valid_o.
  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                       input int lat);
    int n;
    n = 0;
    exp_q.push_back('{data: res, rd: rd, name: name});
    send(mk_inst(FUN7_M, f3, rd), a, b, rd);
    while (bus.valid_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_lat"}, n, lat);
    check1({name, "_busy_rdy"}, bus.ready_o, 1'b0);
  endtask

  // With ready_i=1 the result lasts one cycle and the unit is idle again.
  task automatic settle(input string name);
    @(posedge clk); #1;
    check1({name, "_vld_drop"}, bus.valid_o, 1'b0);
    check1({name, "_idle_rdy"}, bus.ready_o, 1'b1);
  endtask

  task automatic check_cleared(input string name);
    check1({name, "_valid"}, bus.valid_o, 1'b0);
    check1({name, "_we"}, bus.reg_we_o, 1'b0);
    check({name, "_wdata"}, bus.reg_wdata_o, 32'd0);
    check({name, "_rd"}, {27'd0, bus.rd_o}, 32'd0);
    check1({name, "_ready"}, bus.ready_o, 1'b1);
  endtask

  // Scoreboard monitor: compares each completed result handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.valid_o === 1'b1) begin
        check1("we_eq_valid", bus.reg_we_o, 1'b1);
        if (bus.ready_i === 1'b1 && flush !== 1'b1) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid: got rd %0d data 0x%08h, required no result",
                     bus.rd_o, bus.reg_wdata_o);
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_data"}, bus.reg_wdata_o, e.data);
            check({e.name, "_rd"}, {27'd0, bus.rd_o}, {27'd0, e.rd});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    bus.valid_i = 1'b0;
    bus.inst_i  = 32'd0;
    bus.op1_i   = 32'd0;
    bus.op2_i   = 32'd0;
    bus.rd_i    = 5'd0;
    bus.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("mul", FUN3_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 32);
    settle("mul");
    issue("mulh", FUN3_MULH, 32'h80000000, 32'h80000000, 5'd6, 32'h40000000, 32);
    settle("mulh");
    issue("mulhu", FUN3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFE, 32);
    settle("mulhu");
    issue("mulhsu", FUN3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'hFFFFFFFF, 32);
    settle("mulhsu");
    issue("div", FUN3_DIV, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFD, 32);
    settle("div");
    issue("rem", FUN3_REM, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 32);
    settle("rem");
    issue("divu", FUN3_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, 32);
    settle("divu");
    issue("remu", FUN3_REMU, 32'd100, 32'd7, 5'd12, 32'd2, 32);
    settle("remu");

    issue("div_by0", FUN3_DIV, 32'd5, 32'd0, 5'd13, 32'hFFFFFFFF, 0);
    settle("div_by0");
    issue("remu_by0", FUN3_REMU, 32'd5, 32'd0, 5'd14, 32'd5, 0);
    settle("remu_by0");
    issue("div_ovf", FUN3_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 0);
    settle("div_ovf");
    issue("rem_ovf", FUN3_REM, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0, 0);
    settle("rem_ovf");

    // Backpressure: result must hold while ready_i is low.
    bus.ready_i = 1'b0;
    issue("bp", FUN3_MUL, 32'd123, 32'd456, 5'd17, 32'h0000DB18, 32);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check1("bp_hold_valid", bus.valid_o, 1'b1);
      check("bp_hold_data", bus.reg_wdata_o, 32'h0000DB18);
      check("bp_hold_rd", {27'd0, bus.rd_o}, 32'd17);
      check1("bp_hold_rdy", bus.ready_o, 1'b0);
    end
    bus.ready_i = 1'b1;
    settle("bp");

    // Non-M R-type (ADD) is dropped.
    send(mk_inst(7'b0000000, 3'b000, 5'd3), 32'd1, 32'd2, 5'd3);
    for (int i = 0; i < 6; i++) begin
      check1("add_drop_valid", bus.valid_o, 1'b0);
      check1("add_drop_rdy", bus.ready_o, 1'b1);
      @(posedge clk); #1;
    end

    // Flush on iteration 10 of a DIVU.
    send(mk_inst(FUN7_M, FUN3_DIVU, 5'd20), 32'd1000, 32'd3, 5'd20);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check1("flush_idle", bus.ready_o, 1'b1);
    for (int i = 0; i < 40; i++) begin
      check1("flush_no_valid", bus.valid_o, 1'b0);
      @(posedge clk); #1;
    end
    issue("mul_post_flush", FUN3_MUL, 32'h00012345, 32'h00000100, 5'd21, 32'h01234500, 32);
    settle("mul_post_flush");

    // Flush in DONE beats a simultaneous result handshake.
    bus.ready_i = 1'b0;
    send(mk_inst(FUN7_M, FUN3_DIVU, 5'd22), 32'd5, 32'd0, 5'd22);
    check1("flush_done_valid", bus.valid_o, 1'b1);
    flush       = 1'b1;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check1("flush_done_drop", bus.valid_o, 1'b0);
    check1("flush_done_rdy", bus.ready_o, 1'b1);

    // Reset mid-MUL.
    send(mk_inst(FUN7_M, FUN3_MUL, 5'd23), 32'd3, 32'd5, 5'd23);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_cleared("rst_mid_mul");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      check1("rst_mul_no_valid", bus.valid_o, 1'b0);
      @(posedge clk); #1;
    end

    // Reset while a result is held in DONE.
    bus.ready_i = 1'b0;
    send(mk_inst(FUN7_M, FUN3_MUL, 5'd24), 32'd3, 32'd5, 5'd24);
    for (int i = 0; i < 200 && bus.valid_o !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("rst_done_pre_data", bus.reg_wdata_o, 32'd15);
    check("rst_done_pre_rd", {27'd0, bus.rd_o}, 32'd24);
    rst_n = 1'b0;
    #1;
    check_cleared("rst_in_done");
    @(posedge clk); #1;
    rst_n       = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check1("rst_done_no_valid", bus.valid_o, 1'b0);
      @(posedge clk); #1;
    end
    issue("divu_post_rst", FUN3_DIVU, 32'd1000, 32'd3, 5'd25, 32'd333, 32);
    settle("divu_post_rst");

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
